// File: rtl/sub_16bit_signed.sv
// rtl/sub_16bit_signed.sv - 16-bit signed subtractor with registered copy, capture strobe and sticky overflow
module sub_16bit_signed (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        in_valid,
    input  logic        clr_sticky,
    output logic [15:0] result,
    output logic        overflow,
    output logic [15:0] result_q,
    output logic        overflow_q,
    output logic        out_valid,
    output logic        ovf_sticky
);

    logic [15:0] w_b_inv;
    logic [15:0] w_sum;
    logic        w_nb_msb;
    logic        w_ovf;

    logic [15:0] r_result_q;
    logic        r_overflow_q;
    logic        r_out_valid;
    logic        r_ovf_sticky;

    assign w_b_inv = ~B;

    // Ripple-carry adder computing A + ~B + 1 within 16 bits; the final carry is dropped
    always_comb begin
        logic v_c;
        w_sum = 16'd0;
        v_c   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_sum[i] = A[i] ^ w_b_inv[i] ^ v_c;
            v_c      = (A[i] & w_b_inv[i]) | (v_c & (A[i] ^ w_b_inv[i]));
        end
    end

    // Sign bit of the truncated negation ~B + 1: the +1 only ripples into bit 15
    // when B[14:0] is all zero, so B = -32768 negates to itself (sign still set)
    assign w_nb_msb = w_b_inv[15] ^ (B[14:0] == 15'd0);

    // Overflow judged against the truncated negation, not the true negation of B
    assign w_ovf = (A[15] == w_nb_msb) && (w_sum[15] != A[15]);

    assign result   = w_sum;
    assign overflow = w_ovf;

    // Capture the difference and its flag when in_valid is high; strobe out_valid for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q   <= 16'd0;
            r_overflow_q <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result_q   <= w_sum;
                r_overflow_q <= w_ovf;
            end
        end
    end

    // Accumulate captured overflows until cleared; clear takes priority over a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (clr_sticky) begin
            r_ovf_sticky <= 1'b0;
        end else begin
            r_ovf_sticky <= r_ovf_sticky | (in_valid & w_ovf);
        end
    end

    assign result_q   = r_result_q;
    assign overflow_q = r_overflow_q;
    assign out_valid  = r_out_valid;
    assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_sub_16bit_signed.sv
// tb/tb_sub_16bit_signed.sv - randomized self-checking bench for sub_16bit_signed against an arithmetic model
module tb_sub_16bit_signed;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        in_valid;
    logic        clr_sticky;
    logic [15:0] result;
    logic        overflow;
    logic [15:0] result_q;
    logic        overflow_q;
    logic        out_valid;
    logic        ovf_sticky;

    int n_total;
    int n_pass;

    logic [15:0] m_res_q;
    logic        m_ovf_q;
    logic        m_valid;
    logic        m_sticky;

    logic [15:0] corners [9];

    sub_16bit_signed dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .in_valid   (in_valid),
        .clr_sticky (clr_sticky),
        .result     (result),
        .overflow   (overflow),
        .result_q   (result_q),
        .overflow_q (overflow_q),
        .out_valid  (out_valid),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Reference: plain integer difference wrapped to 16 bits; flag uses the wrapped negation of B
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic o);
        int ai, bi, nbi;
        logic [15:0] nb;
        ai  = int'(a);
        bi  = int'(b);
        r   = 16'((ai - bi) & 32'h0000_FFFF);
        nbi = (65536 - bi) & 32'h0000_FFFF;
        nb  = 16'(nbi);
        o   = (a[15] == nb[15]) && (r[15] != a[15]);
    endfunction

    task automatic comb_check(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] er;
        logic        eo;
        A = a;
        B = b;
        #5;
        model(a, b, er, eo);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] er, input logic eo);
        A = a;
        B = b;
        #5;
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    endtask

    // Called 1 time unit after a rising edge; applies inputs, checks comb, then registered outputs after the edge
    task automatic cycle(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic v, input logic c);
        logic [15:0] er;
        logic        eo;
        A          = a;
        B          = b;
        in_valid   = v;
        clr_sticky = c;
        #2;
        model(a, b, er, eo);
        check({tag, "_comb_result"}, 32'(result), 32'(er));
        check({tag, "_comb_overflow"}, 32'(overflow), 32'(eo));
        if (v) begin
            m_res_q = er;
            m_ovf_q = eo;
        end
        m_valid  = v;
        m_sticky = c ? 1'b0 : (m_sticky | (v & eo));
        @(posedge clk);
        #1;
        check({tag, "_result_q"}, 32'(result_q), 32'(m_res_q));
        check({tag, "_overflow_q"}, 32'(overflow_q), 32'(m_ovf_q));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, "_ovf_sticky"}, 32'(ovf_sticky), 32'(m_sticky));
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_result_q"}, 32'(result_q), 32'd0);
        check({tag, "_overflow_q"}, 32'(overflow_q), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ovf_sticky"}, 32'(ovf_sticky), 32'd0);
    endtask

    function automatic logic [15:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 8)];
        return 16'($urandom);
    endfunction

    initial begin
        n_total    = 0;
        n_pass     = 0;
        clk_en     = 1'b0;
        rst_n      = 1'b0;
        A          = 16'd0;
        B          = 16'd0;
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
        m_res_q    = 16'd0;
        m_ovf_q    = 1'b0;
        m_valid    = 1'b0;
        m_sticky   = 1'b0;
        corners    = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000,
                       16'h7FFE, 16'h8001, 16'h4000, 16'hC000};

        #3;
        check_regs_zero("reset");

        // Combinational path with no clock and reset held
        directed("max_minus_m1", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1);
        directed("min_minus_1",  16'h8000, 16'h0001, 16'h7FFF, 1'b1);
        directed("zero_minus_min", 16'h0000, 16'h8000, 16'h8000, 1'b0);
        directed("m1_minus_min", 16'hFFFF, 16'h8000, 16'h7FFF, 1'b1);
        directed("min_minus_min", 16'h8000, 16'h8000, 16'h0000, 1'b1);

        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++)
                comb_check($sformatf("cross_%0d_%0d", i, j), corners[i], corners[j]);

        for (int k = 0; k < 200; k++)
            comb_check("rand_comb", 16'($urandom), 16'($urandom));

        check_regs_zero("reset_after_comb");

        // Start clock with reset still low; release between edges and capture on the very next edge
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check_regs_zero("reset_clocked");
        rst_n = 1'b1;
        cycle("cap_first", 16'h4000, 16'hC000, 1'b1, 1'b0);
        check("cap_first_val", 32'(result_q), 32'h8000);
        check("cap_first_ovf", 32'(overflow_q), 32'd1);
        cycle("hold", 16'h0003, 16'h0001, 1'b0, 1'b0);
        check("hold_val", 32'(result_q), 32'h8000);

        // Clear wins over a simultaneous overflowing capture
        cycle("clr_win", 16'h7FFF, 16'hFFFF, 1'b1, 1'b1);
        check("clr_win_sticky", 32'(ovf_sticky), 32'd0);
        check("clr_win_ovf_q", 32'(overflow_q), 32'd1);

        // Back-to-back captures plus random traffic
        for (int k = 0; k < 300; k++)
            cycle("rand_clk", pick_operand(), pick_operand(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));

        // Mid-stream asynchronous reset with nonzero registers
        cycle("pre_rst", 16'h8000, 16'h0001, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs_zero("async_rst");
        comb_check("comb_in_rst", 16'h1234, 16'h8000);
        m_res_q  = 16'd0;
        m_ovf_q  = 1'b0;
        m_valid  = 1'b0;
        m_sticky = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_regs_zero("rst_held_edge");
        rst_n = 1'b1;
        cycle("post_rst", 16'h0005, 16'h0007, 1'b1, 1'b0);
        cycle("post_rst_idle", 16'h0000, 16'h0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sub_16bit_signed.md
SUB_16BIT_SIGNED -- requirements
Module: sub_16bit_signed

Interface
REQ-001 Parameters: none; the data width SHALL be fixed at 16 bits.
REQ-002 clk  input  1  rising-edge clock for the registered path only.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  16  signed two's-complement minuend.
REQ-005 B  input  16  signed two's-complement subtrahend.
REQ-006 in_valid  input  1  qualifies A/B for capture into the registered path.
REQ-007 clr_sticky  input  1  synchronous clear of ovf_sticky.
REQ-008 result  output  16  combinational signed difference A-B.
REQ-009 overflow  output  1  combinational overflow flag for result.
REQ-010 result_q  output  16  registered copy of result.
REQ-011 overflow_q  output  1  registered copy of overflow.
REQ-012 out_valid  output  1  high for one cycle when result_q/overflow_q are updated.
REQ-013 ovf_sticky  output  1  set by any captured overflow, held until cleared.

Function
REQ-014 result SHALL equal (A + NB) mod 2^16, where NB = (~B + 1) truncated to 16 bits; this is bit-identical to A-B mod 2^16.
REQ-015 overflow SHALL equal (A[15] == NB[15]) AND (result[15] != A[15]), with NB as in REQ-014 and not B's true negation.
REQ-016 For B = -32768, NB = -32768 (sign bit 1). The flag SHALL therefore be 1 when A is negative and result is non-negative, and 0 when A is non-negative, even though the latter case truly overflows.
REQ-017 result and overflow SHALL be purely combinational from A and B, independent of clk, rst_n and in_valid, and settled within one simulation delta window (bench samples 5 ns after input change).
REQ-018 Negation and addition SHALL be built as an explicit 16-bit adder (inverted B plus carry-in 1); no sign extension and no 17-bit result.
REQ-019 On each rising clk edge with in_valid=1: result_q <= result, overflow_q <= overflow, out_valid <= 1.
REQ-020 On each rising clk edge with in_valid=0: result_q and overflow_q SHALL hold, and out_valid <= 0.
REQ-021 Latency of the registered path SHALL be one cycle from in_valid sampled high to out_valid high.
REQ-022 ovf_sticky <= 0 when clr_sticky=1; otherwise ovf_sticky <= ovf_sticky OR (in_valid AND overflow).
REQ-023 When clr_sticky and a captured overflow occur in the same cycle, clear SHALL win (ovf_sticky = 0 next cycle).
REQ-024 Back-to-back in_valid SHALL be accepted every cycle; there is no backpressure.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force result_q=0, overflow_q=0, out_valid=0 and ovf_sticky=0.
REQ-026 Reset SHALL NOT affect the combinational outputs result and overflow.
REQ-027 Deassertion of rst_n SHALL take effect at the next clk edge; an in_valid high on that edge SHALL be captured normally.
REQ-028 Reset asserted mid-stream SHALL discard any pending capture and deassert out_valid immediately.

Verification
REQ-029 A=32767, B=-1 -> result=-32768, overflow=1; A=-32768, B=1 -> result=32767, overflow=1.
REQ-030 A=0, B=-32768 -> result=-32768 (0x8000), overflow=0; A=-1, B=-32768 -> result=32767, overflow=1; A=-32768, B=-32768 -> result=0, overflow=1.
REQ-031 Exhaustive 9x9 cross of {0, 1, -1, 32767, -32768, 32766, -32767, 16384, -16384}, no clock running -> result == A-B mod 2^16 and overflow per REQ-015 for every pair.
REQ-032 Clocked: in_valid=1 with A=16384, B=-16384 -> next cycle result_q=-32768, overflow_q=1, out_valid=1, ovf_sticky=1; then in_valid=0 -> out_valid=0 and values held.
REQ-033 ovf_sticky=1, then clr_sticky=1 with in_valid=1 and an overflowing pair -> ovf_sticky=0 next cycle, overflow_q=1.
REQ-034 rst_n pulled low between clock edges while registers are nonzero -> result_q, overflow_q, out_valid and ovf_sticky read 0 immediately, while result/overflow still track A and B.
